// File: rtl/sort_pkg.sv
// sort_pkg: shared word width, lane count, pad value and loader state encoding
package sort_pkg;
  localparam int WORD_W = 8;
  localparam int N_LANES = 4;
  localparam logic [WORD_W-1:0] PAD_WORD = 8'hFF;
  localparam logic LOAD = 1'b0;
  localparam logic FULL = 1'b1;
  typedef enum logic {ST_LOAD = LOAD, ST_FULL = FULL} state_t;
endpackage

// File: rtl/sort_frame_loader.sv
// sort_frame_loader: packs a serial word stream into 4-word frames for the bottom sorter
module sort_frame_loader
  import sort_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter logic [WIDTH-1:0] PAD = WIDTH'(PAD_WORD),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [WIDTH-1:0] f1,
  output logic [WIDTH-1:0] f2,
  output logic [WIDTH-1:0] f3,
  output logic [WIDTH-1:0] f4,
  output logic [CNT_W-1:0] frame_count
);
  state_t state, state_d;
  logic [1:0] cnt, cnt_d;
  logic [WIDTH-1:0] slot [N_LANES];
  logic [WIDTH-1:0] slot_d [N_LANES];
  logic [CNT_W-1:0] count_d;
  logic acc, last, flush_go;
  logic [2:0] fill_lo;
  assign in_ready = state == ST_LOAD;
  assign acc = in_valid && in_ready;
  assign last = acc && cnt == 2'd3;
  assign flush_go = in_ready && flush && (acc || cnt != 2'd0);
  // first slot left empty after this cycle's beat; everything from here up gets PAD
  assign fill_lo = {1'b0, cnt} + {2'b0, acc};
  assign frame_valid = state == ST_FULL;
  assign {f1, f2, f3, f4} = {slot[0], slot[1], slot[2], slot[3]};
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    slot_d = slot;
    count_d = frame_count;
    if (state == ST_LOAD) begin
      for (int i = 0; i < N_LANES; i++)
        slot_d[i] = (acc && cnt == 2'(i)) ? in_data : (flush_go && 3'(i) >= fill_lo) ? PAD : slot[i];
      cnt_d = cnt + {1'b0, acc};
      state_d = (last || flush_go) ? ST_FULL : ST_LOAD;
      cnt_d = (last || flush_go) ? 2'd0 : cnt_d;
    end else if (frame_ready) begin
      state_d = ST_LOAD;
      count_d = frame_count + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_LOAD;
      cnt <= 2'd0;
      slot <= '{default: '0};
      frame_count <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      slot <= slot_d;
      frame_count <= count_d;
    end
  end
endmodule

// File: tb/tb_sort_frame_loader.sv
// tb_sort_frame_loader: directed and random stimulus checked each cycle against a word-queue model
module tb_sort_frame_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic frame_ready = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic in_ready, frame_valid;
  logic [7:0] f1, f2, f3, f4, frame_count;
  int checks = 0;
  int errors = 0;
  logic m_full;
  logic [7:0] m_f [4];
  int m_n;
  logic [7:0] m_count;
  logic [7:0] a, b;

  sort_frame_loader dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .f1(f1), .f2(f2), .f3(f3), .f4(f4), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    chk("in_ready", 32'(in_ready), 32'(!m_full));
    chk("frame_valid", 32'(frame_valid), 32'(m_full));
    chk("f1", 32'(f1), 32'(m_f[0]));
    chk("f2", 32'(f2), 32'(m_f[1]));
    chk("f3", 32'(f3), 32'(m_f[2]));
    chk("f4", 32'(f4), 32'(m_f[3]));
    chk("frame_count", 32'(frame_count), 32'(m_count));
  endtask

  // one clock of stimulus; the model applies the frame rules before the edge
  task automatic step(input logic v, input logic [7:0] d, input logic fl, input logic r);
    in_valid = v; in_data = d; flush = fl; frame_ready = r;
    if (!m_full) begin
      if (v) begin m_f[m_n] = d; m_n++; end
      if (m_n == 4 || (fl && m_n > 0)) begin
        for (int i = m_n; i < 4; i++) m_f[i] = 8'hFF;
        m_full = 1'b1;
        m_n = 0;
      end
    end else if (r) begin
      m_full = 1'b0;
      m_count++;
    end
    @(posedge clk); #1;
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; frame_ready = 1'b0;
    m_full = 1'b0; m_n = 0; m_count = 8'd0;
    for (int i = 0; i < 4; i++) m_f[i] = 8'd0;
    @(posedge clk); #1;
    compare();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    // 1: frame of 6,2,4,1
    step(1, 8'd6, 0, 0); step(1, 8'd2, 0, 0); step(1, 8'd4, 0, 0); step(1, 8'd1, 0, 0);
    chk("t1_f1", 32'(f1), 32'd6);
    chk("t1_f4", 32'(f4), 32'd1);
    // 2: held frame ignores new data, then handoff
    for (int i = 0; i < 10; i++) step(1, 8'($urandom), 0, 0);
    chk("t2_held", 32'({f1, f2, f3, f4}), 32'h06020401);
    step(0, 8'd0, 0, 1);
    chk("t2_count", 32'(frame_count), 32'd1);
    chk("t2_ready", 32'(in_ready), 32'd1);
    // 3: partial flush, then empty flush produces nothing
    step(1, 8'd9, 0, 1); step(1, 8'd3, 0, 0); step(0, 8'd0, 1, 0);
    chk("t3_frame", 32'({f1, f2, f3, f4}), 32'h0903FFFF);
    step(0, 8'd0, 1, 0);
    chk("t3_full_flush", 32'(frame_valid), 32'd1);
    step(0, 8'd0, 0, 1);
    step(0, 8'd0, 1, 0);
    chk("t3_empty_flush", 32'(frame_valid), 32'd0);
    step(0, 8'd0, 0, 0);
    // 4: flush with the third beat
    a = 8'($urandom); b = 8'($urandom);
    step(1, a, 0, 0); step(1, b, 0, 0); step(1, 8'd7, 1, 0);
    chk("t4_frame", 32'({f1, f2, f3, f4}), {a, b, 8'h07, 8'hFF});
    step(0, 8'd0, 0, 1);
    // flush with the 4th beat is a plain 4th beat
    for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0, 0);
    step(1, 8'h5A, 1, 0);
    chk("t4_last", 32'(f4), 32'h5A);
    step(0, 8'd0, 0, 1);
    // 5: reset mid-frame then a clean frame
    step(1, 8'($urandom), 0, 0); step(1, 8'($urandom), 0, 0);
    do_reset();
    chk("t5_zero", 32'({f1, f2, f3, f4}), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 8'($urandom), 0, 0);
    step(0, 8'd0, 0, 1);
    // random mix of valid, flush and ready
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
    // 6: 256 back-to-back frames at 5 cycles each
    do_reset();
    for (int i = 0; i < 256 * 5; i++) step(1, 8'($urandom), 0, 1);
    chk("t6_wrap", 32'(frame_count), 32'd0);
    chk("t6_phase", 32'(in_ready), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
